// File: rtl/button_event_fsm_if.sv
// button_event_fsm_if: one-deep event handshake between the button classifier and its consumer
// Ports:
//   event_valid  producer -> consumer  event pending
//   event_code   producer -> consumer  0 short, 1 long, 2 double, 3 repeat
//   event_drop   producer -> consumer  sticky lost-event flag
//   event_ack    consumer -> producer  pending event accepted
interface button_event_fsm_if;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_drop;
  logic       event_ack;
  modport master(output event_valid, event_code, event_drop, input event_ack);
  modport slave(input event_valid, event_code, event_drop, output event_ack);
endinterface

// File: rtl/button_event_fsm.sv
// button_event_fsm: classifies a debounced button level into short/long/double/repeat events
// Ports:
//   clk_in        debouncer clock
//   rst_in        synchronous active-high reset
//   button_clean  debounced level, 1 = pressed
//   press_active  1 while in a pressed state (registered)
//   ev            event handshake (valid/code/drop out, ack in)
module button_event_fsm #(
  parameter int LONG_CYCLES   = 5000,
  parameter int DOUBLE_GAP    = 1250,
  parameter int REPEAT_CYCLES = 1000,
  parameter int CNT_W         = 13
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  button_clean,
  output logic                  press_active,
  button_event_fsm_if.master    ev
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD, WAIT_REL} state_t;
  localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_CYCLES - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             emit, restart;
  logic [1:0]       code_n;
  always_comb begin
    state_n = state;
    emit    = 1'b0;
    code_n  = 2'd0;
    restart = 1'b0;
    case (state)
      IDLE:      if (button_clean) state_n = PRESS1;
      PRESS1:    if (!button_clean) state_n = WAIT2;
                 else if (cnt == LONG_END) begin
                   emit    = 1'b1;
                   code_n  = 2'd1;
                   state_n = LONG_HOLD;
                 end
      WAIT2:     if (button_clean) state_n = PRESS2;
                 else if (cnt == GAP_END) begin
                   emit    = 1'b1;
                   code_n  = 2'd0;
                   state_n = IDLE;
                 end
      PRESS2:    if (!button_clean) begin
                   emit    = 1'b1;
                   code_n  = 2'd2;
                   state_n = IDLE;
                 end else if (cnt == LONG_END) begin
                   emit    = 1'b1;
                   code_n  = 2'd2;
                   state_n = WAIT_REL;
                 end
      LONG_HOLD: if (!button_clean) state_n = IDLE;
                 else if (cnt == REP_END) begin
                   emit    = 1'b1;
                   code_n  = 2'd3;
                   restart = 1'b1;
                 end
      WAIT_REL:  if (!button_clean) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // press_active is registered from the next state so it tracks state exactly with no input path
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      press_active <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (state_n != state || restart) ? '0 : cnt + 1'b1;
      press_active <= state_n inside {PRESS1, PRESS2, LONG_HOLD, WAIT_REL};
    end
  end
  // an ack on the same edge frees the slot, so a coincident emit is accepted rather than dropped
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ev.event_valid <= 1'b0;
      ev.event_code  <= 2'd0;
      ev.event_drop  <= 1'b0;
    end else if (emit && (!ev.event_valid || ev.event_ack)) begin
      ev.event_valid <= 1'b1;
      ev.event_code  <= code_n;
    end else if (emit) begin
      ev.event_drop  <= 1'b1;
    end else if (ev.event_ack) begin
      ev.event_valid <= 1'b0;
    end
  end
endmodule
